// File: rtl/bus_interconnect_if.sv
// bus_interconnect_if: master-side request/response and device-side strobe/response bundle.
// The slave modport is the interconnect's view; the master modport is the environment's view
// (masters driving requests and devices driving completions).
interface bus_interconnect_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_MASTER = 2,
    parameter int NUM_DEVICE = 14
);
    logic [NUM_MASTER-1:0]            master_req;
    logic [NUM_MASTER*ADDR_WIDTH-1:0] master_req_addr;
    logic [NUM_MASTER-1:0]            master_read_write;
    logic [NUM_MASTER*DATA_WIDTH-1:0] master_wdata;
    logic [NUM_MASTER*DATA_WIDTH-1:0] master_rdata;
    logic [NUM_MASTER-1:0]            master_gnt;
    logic [NUM_DEVICE*ADDR_WIDTH-1:0] device_addr;
    logic [NUM_DEVICE-1:0]            device_re;
    logic [NUM_DEVICE-1:0]            device_we;
    logic [NUM_DEVICE*DATA_WIDTH-1:0] device_rdata;
    logic [NUM_DEVICE*DATA_WIDTH-1:0] device_wdata;
    logic [NUM_DEVICE-1:0]            device_gnt;

    modport slave (
        input  master_req, master_req_addr, master_read_write, master_wdata, device_rdata, device_gnt,
        output master_rdata, master_gnt, device_addr, device_re, device_we, device_wdata
    );

    modport master (
        output master_req, master_req_addr, master_read_write, master_wdata, device_rdata, device_gnt,
        input  master_rdata, master_gnt, device_addr, device_re, device_we, device_wdata
    );
endinterface

// File: rtl/bus_interconnect.sv
// bus_interconnect: single-outstanding shared bus, NUM_MASTER masters to NUM_DEVICE windows at 0x3N00_0000.
// Optional macro BUS_RR_ARB_EN selects round-robin arbitration; otherwise fixed priority (master 0 highest).
module bus_interconnect #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_MASTER = 2,
    parameter int NUM_DEVICE = 14
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bus_interconnect_if.slave   bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int MW = NUM_MASTER > 1 ? $clog2(NUM_MASTER) : 1;
    localparam logic [4:0] NDEV = 5'(NUM_DEVICE);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                   state_q, state_d;
    logic [MW-1:0]            owner_q, owner_d;
    logic [3:0]               dev_q, dev_d;
    logic [NUM_MASTER*DW-1:0] rdata_q, rdata_d;
    logic [NUM_MASTER-1:0]    gnt_q, gnt_d;
    logic [NUM_DEVICE-1:0]    re_q, re_d;
    logic [NUM_DEVICE-1:0]    we_q, we_d;
    logic [NUM_DEVICE*AW-1:0] daddr_q, daddr_d;
    logic [NUM_DEVICE*DW-1:0] dwdata_q, dwdata_d;

    logic [MW-1:0]            win;
    logic [AW-1:0]            win_addr;
    logic                     win_hit;

`ifdef BUS_RR_ARB_EN
    logic [MW-1:0]            last_q, last_d;

    // Round-robin pick: search starts just after the most recently served master.
    always_comb begin
        int   j;
        logic found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            j = int'(last_q) + 1 + i;
            if (j >= NUM_MASTER) j = j - NUM_MASTER;
            if (!found && bus.master_req[j]) begin
                win   = MW'(j);
                found = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: lowest requesting index wins.
    always_comb begin
        win = '0;
        for (int i = NUM_MASTER - 1; i >= 0; i--)
            if (bus.master_req[i]) win = MW'(i);
    end
`endif

    assign win_addr = bus.master_req_addr[win*AW +: AW];
    assign win_hit  = win_addr[31:28] == 4'h3 && {1'b0, win_addr[27:24]} < NDEV;

    // Next-state and next-output computation for the IDLE/ACCESS/RESP transaction sequence.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        dev_d    = dev_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        re_d     = re_q;
        we_d     = we_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
`ifdef BUS_RR_ARB_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: if (|bus.master_req) begin
                owner_d = win;
`ifdef BUS_RR_ARB_EN
                last_d  = win;
`endif
                if (win_hit) begin
                    state_d                   = ACCESS;
                    dev_d                     = win_addr[27:24];
                    re_d[win_addr[27:24]]     = ~bus.master_read_write[win];
                    we_d[win_addr[27:24]]     = bus.master_read_write[win];
                    daddr_d[win_addr[27:24]*AW +: AW] = {8'h00, win_addr[23:0]};
                    dwdata_d[win_addr[27:24]*DW +: DW] = bus.master_wdata[win*DW +: DW];
                end else begin
                    state_d               = RESP;
                    rdata_d[win*DW +: DW] = '0;
                    gnt_d[win]            = 1'b1;
                end
            end
            ACCESS: if (bus.device_gnt[dev_q]) begin
                state_d                   = RESP;
                rdata_d[owner_q*DW +: DW] = bus.device_rdata[dev_q*DW +: DW];
                gnt_d[owner_q]            = 1'b1;
                re_d                      = '0;
                we_d                      = '0;
                daddr_d                   = '0;
                dwdata_d                  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; asynchronous reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            dev_q    <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            re_q     <= '0;
            we_q     <= '0;
            daddr_q  <= '0;
            dwdata_q <= '0;
`ifdef BUS_RR_ARB_EN
            last_q   <= MW'(NUM_MASTER - 1);
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            dev_q    <= dev_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            re_q     <= re_d;
            we_q     <= we_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
`ifdef BUS_RR_ARB_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.master_rdata = rdata_q;
    assign bus.master_gnt   = gnt_q;
    assign bus.device_re    = re_q;
    assign bus.device_we    = we_q;
    assign bus.device_addr  = daddr_q;
    assign bus.device_wdata = dwdata_q;
endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed checks of read, wait-state write, unmapped, contention and async reset.
module tb_bus_interconnect;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bus_interconnect_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTER(2), .NUM_DEVICE(14)) bus ();

    bus_interconnect #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTER(2), .NUM_DEVICE(14)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic [31:0] addr, input logic rw, input logic [31:0] wd);
        bus.master_req[m]            = 1'b1;
        bus.master_req_addr[m*32 +: 32] = addr;
        bus.master_read_write[m]     = rw;
        bus.master_wdata[m*32 +: 32] = wd;
    endtask

    // One immediate-gnt read: ACCESS cycle, RESP cycle (requests updated there), then IDLE.
    task automatic serve(input int m, input int d, input logic [31:0] rd, input logic [1:0] nreq);
        tick();
        check($sformatf("serve_re_m%0d", m), 32'(bus.device_re), 32'(1) << d);
        tick();
        check($sformatf("serve_gnt_m%0d", m), 32'(bus.master_gnt), 32'(1) << m);
        check($sformatf("serve_rdata_m%0d", m), bus.master_rdata[m*32 +: 32], rd);
        bus.master_req = nreq;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.master_req        = '0;
        bus.master_req_addr   = '0;
        bus.master_read_write = '0;
        bus.master_wdata      = '0;
        bus.device_rdata      = '0;
        bus.device_gnt        = '0;
        tick();
        tick();
        check("rst_gnt", 32'(bus.master_gnt), 32'h0);
        check("rst_re", 32'(bus.device_re), 32'h0);
        check("rst_we", 32'(bus.device_we), 32'h0);
        check("rst_rdata0", bus.master_rdata[31:0], 32'h0);
        check("rst_rdata1", bus.master_rdata[63:32], 32'h0);
        rst_n = 1'b1;
        tick();

        // Read RAM with immediate device_gnt
        bus.device_gnt[0]        = 1'b1;
        bus.device_rdata[31:0]   = 32'h1234_5678;
        req(0, 32'h3000_0010, 1'b0, 32'h0);
        tick();
        check("rd_re", 32'(bus.device_re), 32'h1);
        check("rd_we", 32'(bus.device_we), 32'h0);
        check("rd_addr0", bus.device_addr[31:0], 32'h10);
        check("rd_gnt_c1", 32'(bus.master_gnt), 32'h0);
        tick();
        check("rd_gnt_c2", 32'(bus.master_gnt), 32'h1);
        check("rd_rdata0", bus.master_rdata[31:0], 32'h1234_5678);
        check("rd_re_drop", 32'(bus.device_re), 32'h0);
        bus.master_req = '0;
        tick();
        check("rd_gnt_c3", 32'(bus.master_gnt), 32'h0);

        // Write to device 2 with three strobe cycles
        bus.device_gnt           = '0;
        bus.device_rdata[95:64]  = 32'hDEAD_BEEF;
        req(1, 32'h3200_0004, 1'b1, 32'hA5A5_A5A5);
        tick();
        check("wr_we_c1", 32'(bus.device_we), 32'h4);
        check("wr_re_c1", 32'(bus.device_re), 32'h0);
        check("wr_addr2", bus.device_addr[95:64], 32'h4);
        check("wr_wdata2", bus.device_wdata[95:64], 32'hA5A5_A5A5);
        check("wr_addr0_idle", bus.device_addr[31:0], 32'h0);
        tick();
        check("wr_we_c2", 32'(bus.device_we), 32'h4);
        check("wr_gnt_c2", 32'(bus.master_gnt), 32'h0);
        tick();
        check("wr_we_c3", 32'(bus.device_we), 32'h4);
        bus.device_gnt[2] = 1'b1;
        tick();
        check("wr_gnt_c4", 32'(bus.master_gnt), 32'h2);
        check("wr_we_drop", 32'(bus.device_we), 32'h0);
        check("wr_rdata1", bus.master_rdata[63:32], 32'hDEAD_BEEF);
        check("wr_rdata0_hold", bus.master_rdata[31:0], 32'h1234_5678);
        bus.master_req = '0;
        bus.device_gnt = '0;
        tick();
        check("wr_gnt_c5", 32'(bus.master_gnt), 32'h0);

        // Unmapped addresses: outside 0x3xxx_xxxx and device index beyond NUM_DEVICE
        req(0, 32'h8000_0000, 1'b0, 32'h0);
        tick();
        check("um_gnt", 32'(bus.master_gnt), 32'h1);
        check("um_rdata0", bus.master_rdata[31:0], 32'h0);
        check("um_re", 32'(bus.device_re), 32'h0);
        bus.master_req = '0;
        tick();
        req(1, 32'h3E00_0000, 1'b1, 32'h5555_5555);
        tick();
        check("um14_gnt", 32'(bus.master_gnt), 32'h2);
        check("um14_we", 32'(bus.device_we), 32'h0);
        check("um14_rdata1", bus.master_rdata[63:32], 32'h0);
        bus.master_req = '0;
        tick();

        // Contention: both masters request together
        bus.device_gnt            = '1;
        bus.device_rdata[63:32]   = 32'h1111_1111;
        bus.device_rdata[127:96]  = 32'h3333_3333;
        req(0, 32'h3100_0008, 1'b0, 32'h0);
        req(1, 32'h3300_000C, 1'b0, 32'h0);
`ifdef BUS_RR_ARB_EN
        serve(0, 1, 32'h1111_1111, 2'b11);
        serve(1, 3, 32'h3333_3333, 2'b11);
        serve(0, 1, 32'h1111_1111, 2'b11);
        serve(1, 3, 32'h3333_3333, 2'b00);
`else
        serve(0, 1, 32'h1111_1111, 2'b10);
        serve(1, 3, 32'h3333_3333, 2'b00);
`endif
        check("ct_gnt_idle", 32'(bus.master_gnt), 32'h0);

        // Async reset in the middle of an ACCESS that never completes
        bus.device_gnt = '0;
        req(0, 32'h3500_0000, 1'b0, 32'h0);
        tick();
        check("ar_re_before", 32'(bus.device_re), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_re_cleared", 32'(bus.device_re), 32'h0);
        check("ar_gnt", 32'(bus.master_gnt), 32'h0);
        check("ar_rdata0", bus.master_rdata[31:0], 32'h0);
        check("ar_rdata1", bus.master_rdata[63:32], 32'h0);
        bus.master_req = '0;
        tick();
        tick();
        check("ar_gnt_held", 32'(bus.master_gnt), 32'h0);
        rst_n = 1'b1;
        tick();
        check("ar_gnt_after", 32'(bus.master_gnt), 32'h0);
        bus.device_gnt[0]      = 1'b1;
        bus.device_rdata[31:0] = 32'hCAFE_F00D;
        req(1, 32'h3000_0020, 1'b0, 32'h0);
        tick();
        check("ar_new_addr0", bus.device_addr[31:0], 32'h20);
        check("ar_new_re", 32'(bus.device_re), 32'h1);
        tick();
        check("ar_new_gnt", 32'(bus.master_gnt), 32'h2);
        check("ar_new_rdata1", bus.master_rdata[63:32], 32'hCAFE_F00D);
        bus.master_req = '0;
        tick();
        check("ar_new_gnt_end", 32'(bus.master_gnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
